piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: parallel word width in bits.
REQ-002 SHALL have parameter LANES, default 1: serial bits emitted per beat; DATA_WIDTH mod LANES SHALL be 0 (elaboration error otherwise).
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RSTN  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port PIN  input  DATA_WIDTH  parallel word to serialise.
REQ-006 SHALL have port PIN_VALID  input  1  PIN holds a word.
REQ-007 SHALL have port PIN_READY  output  1  block accepts PIN this cycle.
REQ-008 SHALL have port MSB_FIRST  input  1  order select, sampled with each accepted word (1 = MSB lanes first).
REQ-009 SHALL have port SOUT  output  LANES  current serial beat.
REQ-010 SHALL have port SOUT_VALID  output  1  SOUT holds a valid beat.
REQ-011 SHALL have port SOUT_READY  input  1  consumer takes beat this cycle.
REQ-012 SHALL have port SOUT_LAST  output  1  current beat is final beat of word.

Function
REQ-013 SHALL define BEATS = DATA_WIDTH/LANES; a counter of width clog2(BEATS+1) SHALL track remaining beats.
REQ-014 SHALL implement FSM states IDLE (no word held) and SHIFT (word held, SOUT_VALID=1).
REQ-015 Load SHALL occur on a rising edge where PIN_VALID && PIN_READY: shift register <= PIN, order bit <= MSB_FIRST, counter <= BEATS, state <= SHIFT.
REQ-016 PIN_READY SHALL be combinational: 1 in IDLE, or in SHIFT when SOUT_LAST && SOUT_READY (back-to-back, zero bubble).
REQ-017 Latency: SOUT_VALID SHALL rise the cycle after the load edge with the first beat on SOUT.
REQ-018 A beat SHALL advance only on an edge where SOUT_VALID && SOUT_READY; SOUT and SOUT_VALID SHALL hold stable while SOUT_READY=0.
REQ-019 LSB-first: SOUT SHALL equal register bits [LANES-1:0], register shifts right by LANES; MSB-first: SOUT SHALL equal bits [DATA_WIDTH-1:DATA_WIDTH-LANES], register shifts left by LANES; vacated bits SHALL fill with 0.
REQ-020 SOUT_LAST SHALL be 1 exactly when SOUT_VALID=1 and counter=1.
REQ-021 On final beat accept without simultaneous load: state <= IDLE, SOUT_VALID <= 0, SOUT <= 0.
REQ-022 On final beat accept with simultaneous load: new word SHALL load per REQ-015 and SOUT_VALID SHALL remain 1.
REQ-023 MSB_FIRST and PIN changes outside a load edge SHALL not affect the word in flight.
REQ-024 In IDLE, SOUT SHALL be 0 and SOUT_LAST 0.
REQ-025 LANES = DATA_WIDTH (BEATS=1) SHALL work: every beat is LAST, full-rate pass-through with one-cycle latency.

Reset
REQ-026 When RSTN=0 at a rising edge: state <= IDLE, shift register, counter, order bit <= 0.
REQ-027 Outputs after reset: SOUT=0, SOUT_VALID=0, SOUT_LAST=0; PIN_READY SHALL be 0 while RSTN=0 and 1 in the first cycle after release.
REQ-028 Reset mid-word SHALL discard the word; no partial beats SHALL appear after release.

Structure
REQ-029 Package piso_serializer_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and a clog2-based counter-width function.
REQ-030 Sub-module piso_beat_counter (load value, decrement-on-enable, is_one flag) SHALL implement the beat counter; datapath and FSM SHALL stay in piso_serializer.

Verification
REQ-031 DATA_WIDTH=8, LANES=1, MSB_FIRST=0, PIN=0xA5, SOUT_READY=1 -> SOUT 1,0,1,0,0,1,0,1 on 8 consecutive cycles; LAST on 8th only.
REQ-032 DATA_WIDTH=8, LANES=2, MSB_FIRST=1, PIN=0xC6 -> SOUT 2'b11,2'b00,2'b01,2'b10; LAST on 4th.
REQ-033 LANES=1, SOUT_READY toggled 1,0,0,1,... on 0x81 -> SOUT held stable during stalls; bit sequence unchanged; 8 accepted beats total.
REQ-034 Back-to-back words 0x0F then 0xF0 with PIN_VALID held high, LANES=4 -> beats 4'hF,4'h0,4'h0,4'hF with no SOUT_VALID gap; PIN_READY pulses on each LAST beat.
REQ-035 RSTN=0 asserted after 3rd beat of 0xFF -> next cycle SOUT_VALID=0, SOUT=0; after release PIN_READY=1; new word 0x01 serialises cleanly.
REQ-036 DATA_WIDTH=8, LANES=8, PIN stream 0x11,0x22,0x33 continuous -> SOUT 0x11,0x22,0x33 on successive cycles, LAST=1 every beat.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_serializer_pkg
//   Shared types and helpers for the parallel-in / serial-out serializer.
//   - state_e   : FSM state encoding (IDLE = no word held, SHIFT = word held)
//   - cnt_width : width of a counter that must hold the values 0..beats
// -----------------------------------------------------------------------------
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // A counter that is loaded with 'beats' and counts down to zero needs to
  // represent beats+1 distinct values.
  function automatic int cnt_width(input int beats);
    return (beats < 1) ? 1 : $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/piso_beat_counter.sv
// -----------------------------------------------------------------------------
// piso_beat_counter
//   Remaining-beat down-counter for the serializer.
//   Ports:
//     clk      - clock, rising edge
//     rstn     - synchronous active-low reset (count -> 0)
//     load     - load load_val this edge (wins over dec)
//     load_val - value to load (beats per word)
//     dec      - decrement by one this edge (saturates at zero)
//     is_one   - count equals one, i.e. the current beat is the last
// -----------------------------------------------------------------------------
module piso_beat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    // A load on the same edge as the final-beat decrement starts the next
    // word, so load takes priority.
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign is_one = (count_q == CNT_W'(1));

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out serializer with valid/ready handshakes on both
//   sides. A DATA_WIDTH word is emitted as DATA_WIDTH/LANES beats of LANES
//   bits, LSB lanes first or MSB lanes first as selected per word.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no word held; SOUT = 0, PIN_READY = 1
//   SHIFT  | word held; SOUT_VALID = 1, SOUT carries the current beat
//
//   Ports:
//     CLK        - clock, rising edge
//     RSTN       - synchronous active-low reset
//     PIN        - parallel word to serialise
//     PIN_VALID  - PIN holds a word
//     PIN_READY  - word accepted this cycle (combinational)
//     MSB_FIRST  - beat order, captured with each accepted word
//     SOUT       - current serial beat
//     SOUT_VALID - SOUT holds a valid beat
//     SOUT_READY - consumer takes the beat this cycle
//     SOUT_LAST  - current beat is the final beat of its word
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [DATA_WIDTH-1:0] PIN,
  input  logic                  PIN_VALID,
  output logic                  PIN_READY,
  input  logic                  MSB_FIRST,
  output logic [LANES-1:0]      SOUT,
  output logic                  SOUT_VALID,
  input  logic                  SOUT_READY,
  output logic                  SOUT_LAST
);

  localparam int BEATS = DATA_WIDTH / LANES;
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

  if ((DATA_WIDTH % LANES) != 0) begin : g_bad_lanes
    $error("piso_serializer: DATA_WIDTH must be a multiple of LANES");
  end

  // Beat visible at the output for a given register image and order.
  function automatic logic [LANES-1:0] beat_of(input logic [DATA_WIDTH-1:0] w,
                                               input logic msb);
    return msb ? w[DATA_WIDTH-1 -: LANES] : w[LANES-1:0];
  endfunction

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                  msb_q, msb_d;
  logic [LANES-1:0]      sout_q, sout_d;

  logic                  cnt_is_one;
  logic                  sout_valid;
  logic                  beat_take;
  logic                  last_take;
  logic                  pin_ready;
  logic                  load;
  logic [DATA_WIDTH-1:0] sreg_shifted;

  assign sout_valid = (state_q == ST_SHIFT);
  assign beat_take  = sout_valid && SOUT_READY;
  assign last_take  = beat_take && cnt_is_one;

  // Ready while empty, or when the final beat leaves this cycle so the next
  // word follows with no bubble. Held low during reset.
  assign pin_ready = RSTN && ((state_q == ST_IDLE) || last_take);
  assign load      = PIN_VALID && pin_ready;

  // The register always holds the not-yet-emitted beats aligned to the
  // output end, so zeros fill in from the far side.
  assign sreg_shifted = msb_q ? (sreg_q << LANES) : (sreg_q >> LANES);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    msb_d   = msb_q;
    sout_d  = sout_q;
    if (load) begin
      state_d = ST_SHIFT;
      sreg_d  = PIN;
      msb_d   = MSB_FIRST;
      sout_d  = beat_of(PIN, MSB_FIRST);
    end else if (last_take) begin
      state_d = ST_IDLE;
      sreg_d  = '0;
      sout_d  = '0;
    end else if (beat_take) begin
      sreg_d  = sreg_shifted;
      sout_d  = beat_of(sreg_shifted, msb_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      msb_q   <= 1'b0;
      sout_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      msb_q   <= msb_d;
      sout_q  <= sout_d;
    end
  end

  piso_beat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk      (CLK),
    .rstn     (RSTN),
    .load     (load),
    .load_val (BEATS_C),
    .dec      (beat_take),
    .is_one   (cnt_is_one)
  );

  assign PIN_READY  = pin_ready;
  assign SOUT       = sout_q;
  assign SOUT_VALID = sout_valid;
  assign SOUT_LAST  = sout_valid && cnt_is_one;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic CLK;
  logic RSTN;

  logic [7:0] pin        [4];
  logic       pin_valid  [4];
  logic       pin_ready  [4];
  logic       msb_first  [4];
  logic [7:0] sout_x     [4];
  logic       sout_valid [4];
  logic       sout_ready [4];
  logic       sout_last  [4];

  // Instance g uses LANES = 1 << g : 1, 2, 4, 8.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = 1 << g;
    logic [L-1:0] s;
    piso_serializer #(.DATA_WIDTH(8), .LANES(L)) u_dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .PIN        (pin[g]),
      .PIN_VALID  (pin_valid[g]),
      .PIN_READY  (pin_ready[g]),
      .MSB_FIRST  (msb_first[g]),
      .SOUT       (s),
      .SOUT_VALID (sout_valid[g]),
      .SOUT_READY (sout_ready[g]),
      .SOUT_LAST  (sout_last[g])
    );
    assign sout_x[g] = 8'(s);
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: per instance, a FIFO of expected beats {last, value}.
  logic [8:0] exp_q [4][128];
  int         wr    [4];
  int         rd    [4];

  // Beats the consumer actually took, recorded for literal sequence checks.
  logic [8:0] cap   [4][16];
  int         cap_n [4];

  task automatic check(input string nm, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // k-th beat of word w for a given lane count and order, by plain arithmetic.
  function automatic logic [7:0] beat_val(input logic [7:0] w, input int l,
                                          input logic msb, input int k);
    logic [7:0] m;
    m = 8'((1 << l) - 1);
    if (msb) return (w >> (8 - (k + 1) * l)) & m;
    else     return (w >> (k * l)) & m;
  endfunction

  // Model update on each rising edge.
  initial begin
    logic       em;
    logic [8:0] fr;
    logic       rdy;
    int         b;
    for (int g = 0; g < 4; g++) begin wr[g] = 0; rd[g] = 0; end
    forever begin
      @(posedge CLK);
      for (int g = 0; g < 4; g++) begin
        em  = (wr[g] == rd[g]);
        fr  = exp_q[g][rd[g] % 128];
        rdy = RSTN && (em || (fr[8] && sout_ready[g]));
        if (!RSTN) begin
          rd[g] = wr[g];
        end else begin
          if (!em && sout_ready[g]) rd[g]++;
          if (pin_valid[g] && rdy) begin
            b = 8 >> g;
            for (int k = 0; k < b; k++) begin
              exp_q[g][wr[g] % 128] = {(k == b - 1), beat_val(pin[g], 1 << g, msb_first[g], k)};
              wr[g]++;
            end
          end
        end
      end
    end
  end

  // Compare process: every falling edge, all instances.
  initial begin
    logic       em;
    logic [8:0] fr;
    for (int g = 0; g < 4; g++) cap_n[g] = 0;
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        for (int g = 0; g < 4; g++) begin
          em = (wr[g] == rd[g]);
          fr = exp_q[g][rd[g] % 128];
          check($sformatf("sout_valid[%0d]", g), int'(sout_valid[g]), int'(!em));
          check($sformatf("sout[%0d]", g), int'(sout_x[g]), em ? 0 : int'(fr[7:0]));
          check($sformatf("sout_last[%0d]", g), int'(sout_last[g]), em ? 0 : int'(fr[8]));
          check($sformatf("pin_ready[%0d]", g), int'(pin_ready[g]),
                int'(RSTN && (em || (fr[8] && sout_ready[g]))));
          if (RSTN && sout_valid[g] && sout_ready[g] && cap_n[g] < 16) begin
            cap[g][cap_n[g]] = {sout_last[g], sout_x[g]};
            cap_n[g]++;
          end
        end
      end
    end
  end

  task automatic send(input int g, input logic [7:0] w, input logic m);
    logic acc;
    int   n;
    pin[g] = w; msb_first[g] = m; pin_valid[g] = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge CLK);
      acc = pin_ready[g];
      @(posedge CLK);
      #1;
      n++;
    end
    if (!acc) check($sformatf("send_timeout[%0d]", g), 0, 1);
    pin_valid[g] = 1'b0;
    pin[g] = 8'h5A;      // scribble after load: must not disturb the word in flight
    msb_first[g] = ~m;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    @(negedge CLK);
    while (sout_valid[g] && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check($sformatf("idle_timeout[%0d]", g), 0, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_seq(input string nm, input int g, input int n,
                           input int e[8], input int lastmask);
    check({nm, "_count"}, cap_n[g], n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_beat%0d", nm, i), int'(cap[g][i][7:0]), e[i]);
      check($sformatf("%s_last%0d", nm, i), int'(cap[g][i][8]), (lastmask >> i) & 1);
    end
  endtask

  initial begin
    RSTN = 1'b0;
    for (int g = 0; g < 4; g++) begin
      pin[g] = '0; pin_valid[g] = 1'b0; msb_first[g] = 1'b0; sout_ready[g] = 1'b1;
    end

    // Model pinned against hand-computed beats.
    for (int k = 0; k < 4; k++)
      check($sformatf("model_c6_beat%0d", k), int'(beat_val(8'hC6, 2, 1'b1, k)), (k == 0) ? 3 : k - 1);
    check("model_a5_beat0", int'(beat_val(8'hA5, 1, 1'b0, 0)), 1);
    check("model_a5_beat3", int'(beat_val(8'hA5, 1, 1'b0, 3)), 0);
    check("model_0f_msb", int'(beat_val(8'h0F, 4, 1'b1, 0)), 0);

    @(posedge CLK); #1;
    chk_en = 1'b1;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    @(posedge CLK); #1;

    // 0xA5, LANES=1, LSB first.
    cap_n[0] = 0;
    send(0, 8'hA5, 1'b0);
    wait_idle(0);
    check_seq("a5", 0, 8, '{1, 0, 1, 0, 0, 1, 0, 1}, 8'h80);

    // 0xC6, LANES=2, MSB first.
    cap_n[1] = 0;
    send(1, 8'hC6, 1'b1);
    wait_idle(1);
    check_seq("c6", 1, 4, '{3, 0, 1, 2, 0, 0, 0, 0}, 8'h08);

    // 0x81, LANES=1 with consumer stalls 1,0,0,1,...
    cap_n[0] = 0;
    fork
      send(0, 8'h81, 1'b0);
      for (int i = 0; i < 40; i++) begin
        sout_ready[0] = (i % 4 == 0) || (i % 4 == 3);
        @(posedge CLK); #1;
      end
    join
    sout_ready[0] = 1'b1;
    wait_idle(0);
    check_seq("x81", 0, 8, '{1, 0, 0, 0, 0, 0, 0, 1}, 8'h80);

    // Back-to-back 0x0F then 0xF0, LANES=4.
    cap_n[2] = 0;
    send(2, 8'h0F, 1'b0);
    send(2, 8'hF0, 1'b0);
    wait_idle(2);
    check_seq("b2b", 2, 4, '{15, 0, 0, 15, 0, 0, 0, 0}, 8'h0A);

    // Reset in the middle of 0xFF, then a clean 0x01.
    send(0, 8'hFF, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b0;
    @(negedge CLK);
    check("rst_mid_ready_low", int'(pin_ready[0]), 0);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    @(negedge CLK);
    check("rst_post_valid", int'(sout_valid[0]), 0);
    check("rst_post_ready", int'(pin_ready[0]), 1);
    @(posedge CLK); #1;
    cap_n[0] = 0;
    send(0, 8'h01, 1'b0);
    wait_idle(0);
    check_seq("x01", 0, 8, '{1, 0, 0, 0, 0, 0, 0, 0}, 8'h80);

    // LANES=8 pass-through stream.
    cap_n[3] = 0;
    send(3, 8'h11, 1'b0);
    send(3, 8'h22, 1'b1);
    send(3, 8'h33, 1'b0);
    wait_idle(3);
    check_seq("pass", 3, 3, '{'h11, 'h22, 'h33, 0, 0, 0, 0, 0}, 8'h07);

    // Mixed traffic under a pseudo-random consumer.
    fork
      begin send(1, 8'h3C, 1'b0); send(1, 8'h96, 1'b1); end
      begin send(2, 8'hA7, 1'b1); send(2, 8'h5B, 1'b0); end
      for (int i = 0; i < 60; i++) begin
        sout_ready[1] = 1'($urandom_range(0, 1));
        sout_ready[2] = 1'($urandom_range(0, 1));
        @(posedge CLK); #1;
      end
    join
    sout_ready[1] = 1'b1;
    sout_ready[2] = 1'b1;
    wait_idle(1);
    wait_idle(2);
    repeat (4) @(posedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
